// File: rtl/gcm_frame_loader.sv
// gcm_frame_loader: collects one MACsec frame into AAD, nonce and three plaintext blocks for aes_gcm_top.
// Define GCM_FRAME_CHECK_EN to enforce in_last framing and the EtherType check, with err/drop_cnt reporting.
module gcm_frame_loader #(
  parameter int WORDS_AAD = 7,
  parameter int WORDS_PT  = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             in_data,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic [32*WORDS_AAD-1:0] aad,
  output logic [95:0]             nonce,
  output logic [127:0]            plaintext1,
  output logic [127:0]            plaintext2,
  output logic [127:0]            plaintext3,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    err,
  output logic [7:0]              drop_cnt
);

  localparam int         AAD_W    = 32 * WORDS_AAD;
  localparam int         PT_W     = 32 * WORDS_PT;
  localparam logic [4:0] AAD_END  = 5'(WORDS_AAD);
  localparam logic [4:0] LAST_IDX = 5'(WORDS_AAD + WORDS_PT - 1);

  typedef enum logic [1:0] {COLLECT, FULL, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [4:0]       idx_q, idx_d;
  logic [AAD_W-1:0] aad_q;
  logic [PT_W-1:0]  pt_q;
  logic             in_ready_q;
  logic             accept;
  logic             load_aad;
  logic             load_pt;

`ifdef GCM_FRAME_CHECK_EN
  localparam logic [4:0] ETH_IDX = 5'd3;
  logic       drop;
  logic       err_q;
  logic [7:0] drop_cnt_q;
`else
  logic unused_in_last;
  assign unused_in_last = in_last;
`endif

  assign accept = in_valid && in_ready_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    load_aad = 1'b0;
    load_pt  = 1'b0;
`ifdef GCM_FRAME_CHECK_EN
    drop     = 1'b0;
`endif
    case (state_q)
      COLLECT: begin
        if (accept) begin
          load_aad = (idx_q < AAD_END);
          load_pt  = (idx_q >= AAD_END);
          idx_d    = idx_q + 5'd1;
`ifdef GCM_FRAME_CHECK_EN
          // A bad EtherType drains the rest of the frame unless this word already ends it.
          if (idx_q == ETH_IDX && in_data[31:16] != 16'h88E5) begin
            drop    = 1'b1;
            idx_d   = 5'd0;
            state_d = in_last ? COLLECT : DRAIN;
          end else if (idx_q == LAST_IDX) begin
            idx_d = 5'd0;
            if (in_last) begin
              state_d = FULL;
            end else begin
              drop    = 1'b1;
              state_d = DRAIN;
            end
          end else if (in_last) begin
            drop  = 1'b1;
            idx_d = 5'd0;
          end
`else
          if (idx_q == LAST_IDX) begin
            idx_d   = 5'd0;
            state_d = FULL;
          end
`endif
        end
      end
      FULL: begin
        if (out_ready) state_d = COLLECT;
      end
      DRAIN: begin
        if (accept && in_last) begin
          state_d = COLLECT;
          idx_d   = 5'd0;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // in_ready is registered so it is low during reset and never depends on in_* combinationally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= COLLECT;
      idx_q      <= 5'd0;
      aad_q      <= '0;
      pt_q       <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      in_ready_q <= (state_d != FULL);
      if (load_aad) aad_q <= {aad_q[AAD_W-33:0], in_data};
      if (load_pt)  pt_q  <= {pt_q[PT_W-33:0], in_data};
    end
  end

`ifdef GCM_FRAME_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q      <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      err_q <= drop;
      if (drop && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign err      = err_q;
  assign drop_cnt = drop_cnt_q;
`else
  assign err      = 1'b0;
  assign drop_cnt = 8'd0;
`endif

  // Nonce is SCI (AAD words 5,6) followed by PN (AAD word 4).
  assign in_ready   = in_ready_q;
  assign out_valid  = (state_q == FULL);
  assign aad        = aad_q;
  assign nonce      = {aad_q[63:32], aad_q[31:0], aad_q[95:64]};
  assign plaintext1 = pt_q[PT_W-1     -: 128];
  assign plaintext2 = pt_q[PT_W-1-128 -: 128];
  assign plaintext3 = pt_q[PT_W-1-256 -: 128];

endmodule
